// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC owner, in-order imem requests, decode buffer
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   imem_req_valid/ready/addr      fetch request channel (addr is the PC)
//   imem_resp_valid/data           in-order response words, latency >= 1
//   redirect_valid/target          flush everything and restart fetch at target
//   stall_flag, ds_allowin         decode backpressure; head pops only when allowin && !stall
//   fs_valid/pc/inst/exc_iam       buffer head presented to decode (zeroed when empty)
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        stall_flag,
  input  logic        ds_allowin,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        fs_exc_iam
);
  localparam int          AW      = $clog2(DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]    pc;
  logic [31:0]    resp_pc;      // PC of the next non-dropped response
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  drop;         // stale responses still to be discarded
  logic [CW-1:0]  count;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           halted;

  logic [31:0]    buf_pc   [DEPTH];
  logic [31:0]    buf_inst [DEPTH];
  logic [DEPTH-1:0] buf_exc;

  logic           aligned;
  logic [CW:0]    credit_used;
  logic           head_valid;
  logic           req_fire;
  logic           resp_ok;
  logic           resp_push;
  logic           exc_push;
  logic           push;
  logic           pop;
  logic [31:0]    push_pc;
  logic [31:0]    push_inst;

  always_comb begin
    aligned     = (pc[1:0] == 2'b00);
    credit_used = {1'b0, outstanding} + {1'b0, count};
    head_valid  = (count != '0);
    // Credit covers both in-flight and buffered words, so the buffer can never overflow.
    imem_req_valid = !rst && !halted && !redirect_valid && (credit_used < DEPTH_C) && aligned;
    req_fire    = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    resp_ok     = imem_resp_valid && (outstanding != '0);
    resp_push   = resp_ok && (drop == '0) && !redirect_valid;
    // Misaligned PC: wait for the pipe to drain, then emit one marker entry and halt.
    exc_push    = !halted && !redirect_valid && !aligned && (outstanding == '0) &&
                  (drop == '0) && ({1'b0, count} < DEPTH_C);
    push        = resp_push || exc_push;
    pop         = head_valid && ds_allowin && !stall_flag;
    push_pc     = resp_push ? resp_pc : pc;
    push_inst   = resp_push ? imem_resp_data : NOP;
  end

  assign imem_req_addr = pc;
  assign fs_valid      = head_valid;
  assign fs_pc         = head_valid ? buf_pc[rd_ptr]   : 32'h0;
  assign fs_inst       = head_valid ? buf_inst[rd_ptr] : 32'h0;
  assign fs_exc_iam    = head_valid && buf_exc[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      halted      <= 1'b0;
    end else if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      pc          <= redirect_target;
      resp_pc     <= redirect_target;
      outstanding <= outstanding - CW'(resp_ok);
      drop        <= outstanding - CW'(resp_ok);
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      halted      <= 1'b0;
    end else begin
      if (req_fire)  pc      <= pc + 32'd4;
      if (resp_push) resp_pc <= resp_pc + 32'd4;
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_ok);
      if (resp_ok && (drop != '0)) drop <= drop - CW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (exc_push) halted <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]   <= push_pc;
      buf_inst[wr_ptr] <= push_inst;
      buf_exc[wr_ptr]  <= exc_push;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_resp_tracked: assert (!(imem_resp_valid && (outstanding == '0)));
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall_flag;
  logic        ds_allowin;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        fs_exc_iam;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .stall_flag(stall_flag), .ds_allowin(ds_allowin),
    .fs_valid(fs_valid), .fs_pc(fs_pc), .fs_inst(fs_inst), .fs_exc_iam(fs_exc_iam)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pend[$];
  int          cyc = 0;
  int          lat = 1;
  int          n_cmp = 0;
  int          n_err = 0;
  int          reqs = 0;
  int          xfers = 0;
  logic [31:0] exp_xfer_pc = 32'h0;
  logic [31:0] last_req_addr = 32'hffff_ffff;
  logic        last_req_valid = 1'b0;

  // Instruction word stored at address a: addi x(n), x0, n with n = a/4 + 1.
  function automatic logic [31:0] word(input logic [31:0] a);
    logic [31:0] n;
    n = (a >> 2) + 32'd1;
    return (n << 20) | (n << 7) | 32'h13;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive due response, sample request/transfer, cross the edge, return at negedge.
  task automatic tick();
    logic        fire;
    logic        xfer;
    logic        take;
    logic [31:0] faddr;
    take = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = word(pend[0].addr);
      take = 1'b1;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'hdead_beef;
    end
    #1;
    fire  = imem_req_valid && imem_req_ready;
    faddr = imem_req_addr;
    last_req_valid = imem_req_valid;
    if (fire) last_req_addr = faddr;
    xfer = fs_valid && ds_allowin && !stall_flag;
    if (xfer) begin
      chk("xfer_pc", fs_pc, exp_xfer_pc);
      chk("xfer_inst", fs_inst, (exp_xfer_pc[1:0] != 2'b00) ? 32'h0000_0013 : word(exp_xfer_pc));
      exp_xfer_pc += 32'd4;
      xfers++;
    end
    @(posedge clk);
    if (take) void'(pend.pop_front());
    if (fire) begin
      pend.push_back('{faddr, cyc + lat});
      reqs++;
    end
    cyc++;
    @(negedge clk);
    imem_resp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    stall_flag = 1'b0;
    ds_allowin = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_fs_valid", 32'(fs_valid), 32'h0);
    chk("rst_fs_pc", fs_pc, 32'h0);
    chk("rst_fs_inst", fs_inst, 32'h0);
    chk("rst_fs_exc", 32'(fs_exc_iam), 32'h0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);

    // Streaming, 1-cycle latency
    imem_req_ready = 1'b1;
    rst = 1'b0;
    tick();
    chk("first_cycle_valid", 32'(fs_valid), 32'h0);
    chk("first_req_addr", last_req_addr, 32'h0);
    tick();
    chk("s0_valid", 32'(fs_valid), 32'h1);
    chk("s0_pc", fs_pc, 32'h0);
    chk("s0_inst", fs_inst, 32'h0010_0093);
    chk("s0_exc", 32'(fs_exc_iam), 32'h0);
    tick();
    chk("s1_pc", fs_pc, 32'h4);
    chk("s1_inst", fs_inst, 32'h0020_0113);
    tick();
    chk("s2_pc", fs_pc, 32'h8);
    chk("s2_inst", fs_inst, 32'h0030_0193);

    // Decode backpressure: credit limit caps in-flight + buffered at 4
    ds_allowin = 1'b0;
    repeat (5) begin
      tick();
      chk("bp_hold_pc", fs_pc, 32'h8);
      chk("bp_hold_inst", fs_inst, 32'h0030_0193);
    end
    chk("bp_req_blocked", 32'(last_req_valid), 32'h0);
    chk("bp_credit_fill", 32'(reqs - xfers), 32'h4);
    ds_allowin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_release_pc", fs_pc, 32'hC + 32'(4 * i));
      chk("bp_release_inst", fs_inst, word(32'hC + 32'(4 * i)));
    end

    // Load-use stall holds the head
    stall_flag = 1'b1;
    repeat (2) begin
      tick();
      chk("stall_hold_pc", fs_pc, 32'h18);
    end
    stall_flag = 1'b0;
    tick();
    chk("stall_next_pc", fs_pc, 32'h1C);
    tick();
    chk("stall_next2_pc", fs_pc, 32'h20);

    // Drain
    imem_req_ready = 1'b0;
    repeat (4) tick();
    chk("drain_empty", 32'(fs_valid), 32'h0);
    chk("drain_inst_zero", fs_inst, 32'h0);

    // 3-cycle latency, three requests in flight, redirect to 0x200
    lat = 3;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h10;
    tick();
    redirect_valid = 1'b0;
    exp_xfer_pc = 32'h10;
    repeat (3) tick();
    chk("lat3_last_req", last_req_addr, 32'h18);
    redirect_valid = 1'b1;
    redirect_target = 32'h200;
    tick();
    chk("redir_no_req", 32'(last_req_valid), 32'h0);
    redirect_valid = 1'b0;
    exp_xfer_pc = 32'h200;
    repeat (3) begin
      tick();
      chk("redir_stale_invisible", 32'(fs_valid), 32'h0);
    end
    tick();
    chk("redir_valid", 32'(fs_valid), 32'h1);
    chk("redir_pc", fs_pc, 32'h200);
    chk("redir_inst", fs_inst, 32'h0810_4093);

    // Redirect coinciding with ready, a response and a transfer
    redirect_valid = 1'b1;
    redirect_target = 32'h400;
    tick();
    chk("coinc_no_req", 32'(last_req_valid), 32'h0);
    chk("coinc_flush", 32'(fs_valid), 32'h0);
    redirect_valid = 1'b0;
    exp_xfer_pc = 32'h400;
    repeat (3) begin
      tick();
      chk("coinc_stale_invisible", 32'(fs_valid), 32'h0);
    end
    tick();
    chk("coinc_pc", fs_pc, 32'h400);
    chk("coinc_inst", fs_inst, 32'h1010_8093);

    // Misaligned redirect target
    redirect_valid = 1'b1;
    redirect_target = 32'h202;
    tick();
    redirect_valid = 1'b0;
    ds_allowin = 1'b0;
    exp_xfer_pc = 32'h202;
    repeat (2) begin
      tick();
      chk("mis_drain_valid", 32'(fs_valid), 32'h0);
      chk("mis_no_req", 32'(last_req_valid), 32'h0);
    end
    tick();
    chk("mis_valid", 32'(fs_valid), 32'h1);
    chk("mis_pc", fs_pc, 32'h202);
    chk("mis_inst", fs_inst, 32'h0000_0013);
    chk("mis_exc", 32'(fs_exc_iam), 32'h1);
    repeat (2) begin
      tick();
      chk("mis_halted_no_req", 32'(last_req_valid), 32'h0);
      chk("mis_hold_pc", fs_pc, 32'h202);
    end

    // Redirect resumes fetch
    lat = 1;
    ds_allowin = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h300;
    tick();
    redirect_valid = 1'b0;
    exp_xfer_pc = 32'h300;
    tick();
    chk("resume_req_valid", 32'(last_req_valid), 32'h1);
    chk("resume_req_addr", last_req_addr, 32'h300);
    tick();
    chk("resume_pc", fs_pc, 32'h300);
    chk("resume_inst", fs_inst, 32'h0C10_6093);
    chk("resume_exc", 32'(fs_exc_iam), 32'h0);

    // Asynchronous reset mid-stream with imem idle
    imem_req_ready = 1'b0;
    ds_allowin = 1'b0;
    tick();
    chk("pre_rst_valid", 32'(fs_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(fs_valid), 32'h0);
    chk("async_rst_pc", fs_pc, 32'h0);
    chk("async_rst_inst", fs_inst, 32'h0);
    chk("async_rst_exc", 32'(fs_exc_iam), 32'h0);
    chk("async_rst_req", 32'(imem_req_valid), 32'h0);
    pend.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    imem_req_ready = 1'b1;
    ds_allowin = 1'b1;
    exp_xfer_pc = 32'h0;
    tick();
    chk("restart_req_valid", 32'(last_req_valid), 32'h1);
    chk("restart_req_addr", last_req_addr, 32'h0);
    tick();
    chk("restart_valid", 32'(fs_valid), 32'h1);
    chk("restart_pc", fs_pc, 32'h0);
    chk("restart_inst", fs_inst, 32'h0010_0093);
    tick();
    chk("restart_pc2", fs_pc, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
